cache_mem_arbiter: RTL and testbench



---
 rtl/cache_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - icache/dcache arbiter onto one burst memory port
//
// Purpose: serves one cacheline transaction at a time, splitting a 256-bit
// line into BEATS bursts of BEAT_W bits (beat 0 = low bits) and returning a
// one-cycle *_resp to the owning cache.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   icache_*            icache line read request / line response
//   dcache_*            dcache line read or writeback request / line response
//   mem_*               burst port: held strobe + address, one mem_resp per beat
// Option: CACHE_ARB_RR_EN selects round-robin priority on conflicts; when
// undefined the dcache always wins.
module cache_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int BEATS  = LINE_W / BEAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              icache_read,
  input  logic [31:0]       icache_addr,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [31:0]       dcache_addr,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              i_resp_q;
  logic              d_resp_q;

  logic              dc_req;
  logic              dc_win_d;
  logic              last_beat;

  assign dc_req    = dcache_read | dcache_write;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

`ifdef CACHE_ARB_RR_EN
  // Client granted at the last conflict (0 = icache, 1 = dcache); only
  // conflicts move it, so a lone request never steals the other's turn.
  logic last_grant_q;

  assign dc_win_d = dc_req & (~icache_read | ~last_grant_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= 1'b0;
    end else if (state_q == IDLE && dc_req && icache_read) begin
      last_grant_q <= dc_win_d;
    end
  end
`else
  assign dc_win_d = dc_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (dc_win_d) begin
            addr_q <= {dcache_addr[31:OFF_W], OFF_W'(0)};
            // A simultaneous read+write is illegal; the writeback wins.
            if (dcache_write) begin
              state_q     <= D_WR;
              mem_write_q <= 1'b1;
              wdata_q     <= dcache_wdata;
            end else begin
              state_q    <= D_RD;
              mem_read_q <= 1'b1;
            end
          end else if (icache_read) begin
            addr_q     <= {icache_addr[31:OFF_W], OFF_W'(0)};
            state_q    <= I_RD;
            mem_read_q <= 1'b1;
          end
        end
        I_RD, D_RD: begin
          if (mem_resp) begin
            // Beats shift in from the top so beat 0 ends in the low slice.
            if (state_q == D_RD) begin
              d_rdata_q <= {mem_rdata, d_rdata_q[LINE_W-1:BEAT_W]};
            end else begin
              i_rdata_q <= {mem_rdata, i_rdata_q[LINE_W-1:BEAT_W]};
            end
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              state_q    <= DONE;
              mem_read_q <= 1'b0;
              if (state_q == D_RD) d_resp_q <= 1'b1;
              else                 i_resp_q <= 1'b1;
            end
          end
        end
        D_WR: begin
          if (mem_resp) begin
            // Low slice is always the current beat; shifting empties the line.
            wdata_q <= wdata_q >> BEAT_W;
            cnt_q   <= cnt_q + 1'b1;
            if (last_beat) begin
              state_q     <= DONE;
              mem_write_q <= 1'b0;
              d_resp_q    <= 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign icache_rdata = i_rdata_q;
  assign icache_resp  = i_resp_q;
  assign dcache_rdata = d_rdata_q;
  assign dcache_resp  = d_resp_q;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q[BEAT_W-1:0];

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         icache_read;
  logic [31:0]  icache_addr;
  logic [255:0] icache_rdata;
  logic         icache_resp;
  logic         dcache_read;
  logic         dcache_write;
  logic [31:0]  dcache_addr;
  logic [255:0] dcache_wdata;
  logic [255:0] dcache_rdata;
  logic         dcache_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  logic         m_resp = 1'b0;
  logic [63:0]  m_rdata = '0;
  logic         stray_resp = 1'b0;
  int           stall = 0;
  logic [255:0] exp_wline = '0;
  logic [31:0]  last_addr = '0;

  assign mem_resp  = m_resp | stray_resp;
  assign mem_rdata = stray_resp ? 64'hDEADBEEF_CAFEF00D : m_rdata;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .icache_read(icache_read), .icache_addr(icache_addr),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [255:0] LINE_A = {64'h4444444444444444, 64'h3333333333333333,
                                     64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] LINE_B = 256'hA5A5A5A5_00000001_5A5A5A5A_00000002_C3C3C3C3_00000003_3C3C3C3C_00000004;
  localparam logic [255:0] LINE_C = 256'h0123456789ABCDEF_1122334455667788_99AABBCCDDEEFF00_F0E1D2C3B4A59687;
  localparam logic [255:0] LINE_D = 256'hFEEDFACE_0BADF00D_12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0;

  // Burst memory model: answers strobes after `stall` idle cycles per beat.
  logic [255:0] mem [logic [31:0]];
  int           beat = 0;
  int           waitc = 0;
  logic [31:0]  burst_addr = '0;
  logic [255:0] wbuf = '0;

  always @(negedge clk) begin
    logic [255:0] tmp;
    m_resp = 1'b0;
    if (!(mem_read || mem_write) || !reset) begin
      beat  = 0;
      waitc = 0;
    end else begin
      if (mem_read && mem_write) chk("strobe_exclusive", 1, 0);
      if (beat == 0 && waitc == 0) burst_addr = mem_addr;
      else chk("mem_addr_held", mem_addr, burst_addr);
      if (mem_write) chk("mem_wdata_slice", mem_wdata, exp_wline[beat*64 +: 64]);
      if (waitc < stall) begin
        waitc++;
      end else begin
        waitc  = 0;
        m_resp = 1'b1;
        if (mem_read) begin
          tmp     = mem.exists(burst_addr) ? mem[burst_addr] : '0;
          m_rdata = tmp[beat*64 +: 64];
        end else begin
          wbuf[beat*64 +: 64] = mem_wdata;
        end
        if (beat == 3) begin
          if (mem_write) mem[burst_addr] = wbuf;
          last_addr = burst_addr;
          beat = 0;
        end else begin
          beat++;
        end
      end
    end
  end

  // Scoreboard of line responses in the order the arbiter must grant them.
  typedef struct {
    bit           dc;
    bit           wr;
    logic [255:0] line;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (icache_resp || dcache_resp) begin
      chk("resp_strobes_low", {mem_read, mem_write}, 2'b00);
      if (sb.size() == 0) begin
        chk("unexpected_resp", {icache_resp, dcache_resp}, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("resp_client", {icache_resp, dcache_resp}, e.dc ? 2'b01 : 2'b10);
        if (!e.wr) chk(e.dc ? "dcache_rdata" : "icache_rdata",
                       e.dc ? dcache_rdata : icache_rdata, e.line);
      end
    end
  end

  task automatic do_txn(input bit dc, input bit wr, input logic [31:0] addr,
                        input logic [255:0] data, output int lat);
    bit got = 0;
    lat = 0;
    if (dc) begin
      dcache_addr  = addr;
      dcache_wdata = data;
      dcache_read  = !wr;
      dcache_write = wr;
    end else begin
      icache_addr = addr;
      icache_read = 1'b1;
    end
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      got = dc ? dcache_resp : icache_resp;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: dc=%0d no resp after %0d cycles", dc, lat);
    end
    @(negedge clk);
    if (dc) begin
      dcache_read  = 1'b0;
      dcache_write = 1'b0;
    end else begin
      icache_read = 1'b0;
    end
  endtask

  typedef struct {
    bit           dc;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int           stall;
  } vec_t;
  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, lat2;
    vecs[0] = '{0, 0, 32'h0000_0064, LINE_A, 0};
    vecs[1] = '{1, 1, 32'h0000_0200, LINE_C, 3};
    vecs[2] = '{1, 0, 32'h0000_021F, LINE_C, 1};
    vecs[3] = '{0, 0, 32'h0000_1004, LINE_B, 2};
    vecs[4] = '{1, 1, 32'h0000_1000, LINE_D, 0};
    vecs[5] = '{0, 0, 32'h0000_1010, LINE_D, 0};
    vecs[6] = '{1, 0, 32'h0000_007C, LINE_A, 0};
    mem[32'h60]   = LINE_A;
    mem[32'h1000] = LINE_B;

    reset = 1'b0;
    icache_read = 1'b0; icache_addr = '0;
    dcache_read = 1'b0; dcache_write = 1'b0; dcache_addr = '0; dcache_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_strobes", {mem_read, mem_write}, 2'b00);
    chk("rst_resp", {icache_resp, dcache_resp}, 2'b00);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_icache_rdata", icache_rdata, 0);
    chk("rst_dcache_rdata", dcache_rdata, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      stall = vecs[i].stall;
      if (vecs[i].wr) exp_wline = vecs[i].data;
      sb.push_back('{vecs[i].dc, vecs[i].wr, vecs[i].data});
      do_txn(vecs[i].dc, vecs[i].wr, vecs[i].addr, vecs[i].data, lat);
      chk($sformatf("v%0d_latency", i), lat, 5 + 4 * vecs[i].stall);
      chk($sformatf("v%0d_mem_addr", i), last_addr, {vecs[i].addr[31:5], 5'b0});
    end

    // Reset after beat 1 of an icache read: burst abandoned, no response.
    stall = 0;
    icache_addr = 32'h0000_0064;
    icache_read = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    icache_read = 1'b0;
    @(negedge clk);
    chk("midrst_mem_read", mem_read, 0);
    chk("midrst_no_resp", icache_resp, 0);
    chk("midrst_rdata_cleared", icache_rdata, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_idle_no_strobe", mem_read, 0);
    sb.push_back('{0, 0, LINE_A});
    do_txn(0, 0, 32'h0000_0064, '0, lat);
    chk("midrst_reissue_latency", lat, 5);

    // First conflict after reset: dcache served first in both modes.
    sb.push_back('{1, 0, LINE_C});
    sb.push_back('{0, 0, LINE_A});
    fork
      do_txn(1, 0, 32'h0000_0200, '0, lat);
      do_txn(0, 0, 32'h0000_0060, '0, lat2);
    join
    chk("conflict1_d_latency", lat, 5);

    // Second conflict: round-robin hands the turn to the icache.
`ifdef CACHE_ARB_RR_EN
    sb.push_back('{0, 0, LINE_C});
    sb.push_back('{1, 0, LINE_A});
`else
    sb.push_back('{1, 0, LINE_A});
    sb.push_back('{0, 0, LINE_C});
`endif
    fork
      do_txn(1, 0, 32'h0000_0060, '0, lat);
      do_txn(0, 0, 32'h0000_0200, '0, lat2);
    join

    // Stray mem_resp while idle must not advance the beat counter.
    stray_resp = 1'b1;
    repeat (2) @(negedge clk);
    stray_resp = 1'b0;
    chk("stray_no_strobe", {mem_read, mem_write}, 2'b00);
    chk("stray_no_resp", {icache_resp, dcache_resp}, 2'b00);
    @(negedge clk);
    sb.push_back('{1, 0, LINE_D});
    do_txn(1, 0, 32'h0000_1000, '0, lat);
    chk("stray_read_latency", lat, 5);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
